// File: rtl/timing_nco_pkg.sv
// timing_nco_pkg
// Shared widths and control-word helpers for the symbol timing recovery
// chain. The loop filter, NCO and interpolator all derive the nominal
// control word and its clamp window from the functions below.
package timing_nco_pkg;

  localparam int FE_W  = 32;
  localparam int ETA_W = 32;
  localparam int MU_W  = 16;

  // Sums against the nominal word are done at this width so that
  // W_NOM + fe cannot wrap before clamping.
  localparam int SUM_W = ETA_W + 2;

  typedef logic [ETA_W-1:0]        eta_t;
  typedef logic [MU_W-1:0]         mu_t;
  typedef logic signed [FE_W-1:0]  fe_t;
  typedef logic [SUM_W-1:0]        wsum_t;

  // Nominal NCO decrement: one modulo-1 wrap every 2^sps_log2 samples.
  function automatic wsum_t w_nom(input int sps_log2);
    wsum_t one;
    one = wsum_t'(1);
    return one << (ETA_W - sps_log2);
  endfunction

  function automatic wsum_t w_lo(input int sps_log2);
    return w_nom(sps_log2) - (w_nom(sps_log2) >> 2);
  endfunction

  function automatic wsum_t w_hi(input int sps_log2);
    return w_nom(sps_log2) + (w_nom(sps_log2) >> 2);
  endfunction

endpackage

// File: rtl/timing_nco_if.sv
// timing_nco_if
// Groups the loop-filter side inputs and interpolator side outputs of the
// timing NCO.
//   master : loop filter / sample source (drives sample_en, fe, loop_out_en)
//   slave  : timing_nco (drives strobe, mu, sym_strobe, w_mon)
interface timing_nco_if;
  import timing_nco_pkg::*;

  logic        sample_en;
  fe_t         fe;
  logic        loop_out_en;
  logic        strobe;
  mu_t         mu;
  logic        sym_strobe;
  eta_t        w_mon;

  modport master (
    output sample_en, fe, loop_out_en,
    input  strobe, mu, sym_strobe, w_mon
  );

  modport slave (
    input  sample_en, fe, loop_out_en,
    output strobe, mu, sym_strobe, w_mon
  );
endinterface

// File: rtl/timing_nco_mu_calc.sv
// nco_mu_calc
// Combinational fractional-interval estimate from the pre-decrement NCO
// phase: mu = sat16((eta << SPS_LOG2) >> 16). At nominal W this equals
// eta / W in Q0.16.
//   eta_i : NCO phase before the underflowing decrement (Q0.32)
//   mu_o  : fractional interval (Q0.16), 0xFFFF when saturated
module nco_mu_calc
  import timing_nco_pkg::*;
#(
  parameter int SPS_LOG2 = 1
) (
  input  eta_t eta_i,
  output mu_t  mu_o
);

  // Bits [47:16] of the scaled value are the integer part; anything set
  // there means eta/W has reached 1.0 and mu saturates.
  logic [47:0] scaled;

  always_comb begin
    scaled = 48'(({32'd0, eta_i} << SPS_LOG2) >> 16);
    mu_o   = (|scaled[47:16]) ? {MU_W{1'b1}} : scaled[15:0];
  end

endmodule

// File: rtl/timing_nco.sv
// timing_nco
// Modulo-1 decrementing NCO and interpolation controller for the Gardner
// timing loop. The latched loop-filter word adjusts the NCO decrement; each
// phase underflow raises an interpolator strobe with its fractional
// interval mu, and every second strobe is flagged as the on-time symbol.
//   clk          : system clock
//   reset        : synchronous, active-high
//   bus.sample_en   (in)  : input sample valid, NCO steps only here
//   bus.fe          (in)  : signed loop filter output
//   bus.loop_out_en (in)  : fe valid, loads fe_hold
//   bus.strobe      (out) : interpolant due, one-cycle pulse
//   bus.mu          (out) : Q0.16 fractional interval, held between strobes
//   bus.sym_strobe  (out) : on-time interpolant, subset of strobe
//   bus.w_mon       (out) : current clamped control word
module timing_nco
  import timing_nco_pkg::*;
#(
  parameter int SPS_LOG2 = 1,
  parameter int FE_SHIFT = 0
) (
  input  logic           clk,
  input  logic           reset,
  timing_nco_if.slave    bus
);

  localparam wsum_t W_NOM = w_nom(SPS_LOG2);
  localparam wsum_t W_LO  = w_lo(SPS_LOG2);
  localparam wsum_t W_HI  = w_hi(SPS_LOG2);

  fe_t                    fe_hold_q, fe_hold_d;
  eta_t                   eta_q, eta_d;
  logic                   phase_q, phase_d;
  logic                   strobe_q, strobe_d;
  logic                   sym_strobe_q, sym_strobe_d;
  mu_t                    mu_q, mu_d;
  eta_t                   w_mon_q;

  fe_t                    fe_shifted;
  logic signed [SUM_W-1:0] w_sum;
  eta_t                   w_cur;
  logic [ETA_W:0]         diff;
  logic                   underflow;
  mu_t                    mu_calc;

  // Control word from the currently held fe; a same-cycle fe load only
  // affects the following step.
  always_comb begin
    fe_shifted = fe_hold_q >>> FE_SHIFT;
    w_sum      = $signed(W_NOM) + $signed({{2{fe_shifted[FE_W-1]}}, fe_shifted});
    if (w_sum < $signed(W_LO)) begin
      w_cur = W_LO[ETA_W-1:0];
    end else if (w_sum > $signed(W_HI)) begin
      w_cur = W_HI[ETA_W-1:0];
    end else begin
      w_cur = w_sum[ETA_W-1:0];
    end
  end

  // Borrow out of the 33-bit subtract marks the modulo-1 wrap.
  always_comb begin
    diff      = {1'b0, eta_q} - {1'b0, w_cur};
    underflow = diff[ETA_W];
  end

  nco_mu_calc #(
    .SPS_LOG2 (SPS_LOG2)
  ) u_mu_calc (
    .eta_i (eta_q),
    .mu_o  (mu_calc)
  );

  always_comb begin
    fe_hold_d    = bus.loop_out_en ? bus.fe : fe_hold_q;
    eta_d        = eta_q;
    phase_d      = phase_q;
    mu_d         = mu_q;
    strobe_d     = 1'b0;
    sym_strobe_d = 1'b0;
    if (bus.sample_en) begin
      eta_d = diff[ETA_W-1:0];
      if (underflow) begin
        strobe_d     = 1'b1;
        sym_strobe_d = phase_q;
        phase_d      = ~phase_q;
        mu_d         = mu_calc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fe_hold_q    <= '0;
      eta_q        <= '1;
      phase_q      <= 1'b0;
      strobe_q     <= 1'b0;
      sym_strobe_q <= 1'b0;
      mu_q         <= '0;
      w_mon_q      <= W_NOM[ETA_W-1:0];
    end else begin
      fe_hold_q    <= fe_hold_d;
      eta_q        <= eta_d;
      phase_q      <= phase_d;
      strobe_q     <= strobe_d;
      sym_strobe_q <= sym_strobe_d;
      mu_q         <= mu_d;
      w_mon_q      <= w_cur;
    end
  end

  assign bus.strobe     = strobe_q;
  assign bus.sym_strobe = sym_strobe_q;
  assign bus.mu         = mu_q;
  assign bus.w_mon      = w_mon_q;

endmodule
